// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter that serialises NumReq register masters onto one downstream port.
// Optional downstream-ready watchdog: define REG_BUS_ARBITER_TIMEOUT_EN.
module reg_bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumReq-1:0]               req_valid_i,
  input  logic [NumReq-1:0]               req_write_i,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0]   req_wstrb_i,
  output logic [NumReq-1:0]               req_ready_o,
  output logic [DataWidth-1:0]            rsp_rdata_o,
  output logic                            rsp_error_o,
  output logic                            dn_valid_o,
  output logic                            dn_write_o,
  output logic [AddrWidth-1:0]            dn_addr_o,
  output logic [DataWidth-1:0]            dn_wdata_o,
  output logic [DataWidth/8-1:0]          dn_wstrb_o,
  input  logic                            dn_ready_i,
  input  logic [DataWidth-1:0]            dn_rdata_i,
  input  logic                            dn_error_i,
  output logic                            busy_o,
  output logic [$clog2(NumReq)-1:0]       grant_idx_o,
  output logic                            timeout_o
);

  localparam int IdxWidth  = $clog2(NumReq);
  localparam int StrbWidth = DataWidth / 8;

  if (NumReq < 2 || NumReq > 8 || (DataWidth % 8) != 0 || TimeoutCycles < 2) begin : g_param_check
    $error("reg_bus_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [IdxWidth-1:0]   rr_ptr;
  logic [IdxWidth-1:0]   grant_idx;
  logic [IdxWidth-1:0]   pick_idx;
  logic [IdxWidth-1:0]   cand_idx;
  logic [IdxWidth-1:0]   ptr_next;
  logic                  pick_found;
  int                    cand;
  logic                  lat_write;
  logic [AddrWidth-1:0]  lat_addr;
  logic [DataWidth-1:0]  lat_wdata;
  logic [StrbWidth-1:0]  lat_wstrb;
  logic                  complete;
  logic                  timeout_hit;
  logic                  done;

  logic [AddrWidth-1:0]  addr_arr  [NumReq];
  logic [DataWidth-1:0]  wdata_arr [NumReq];
  logic [StrbWidth-1:0]  wstrb_arr [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    assign addr_arr[gi]    = req_addr_i[gi*AddrWidth +: AddrWidth];
    assign wdata_arr[gi]   = req_wdata_i[gi*DataWidth +: DataWidth];
    assign wstrb_arr[gi]   = req_wstrb_i[gi*StrbWidth +: StrbWidth];
    assign req_ready_o[gi] = done && (grant_idx == IdxWidth'(gi));
  end

  // Scan from the highest offset down so the valid requester nearest rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int off = NumReq - 1; off >= 0; off--) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = IdxWidth'(cand);
      if (req_valid_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign ptr_next = (grant_idx == IdxWidth'(NumReq - 1)) ? '0 : grant_idx + 1'b1;

  // A reset edge drops any in-flight response, so completions are masked by rst_i.
  assign complete = (state == BUSY) && dn_ready_i && !rst_i;

`ifdef REG_BUS_ARBITER_TIMEOUT_EN
  localparam int CntWidth = $clog2(TimeoutCycles);

  logic [CntWidth-1:0] wd_cnt;

  assign timeout_hit = (state == BUSY) && !dn_ready_i && !rst_i &&
                       (wd_cnt == CntWidth'(TimeoutCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || state == IDLE) begin
      wd_cnt <= '0;
    end else if (!dn_ready_i && !timeout_hit) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign done        = complete || timeout_hit;
  assign rsp_rdata_o = complete ? dn_rdata_i : '0;
  assign rsp_error_o = complete ? dn_error_i : timeout_hit;
  assign timeout_o   = timeout_hit;

  assign dn_valid_o  = (state == BUSY);
  assign busy_o      = (state == BUSY);
  assign grant_idx_o = grant_idx;
  assign dn_write_o  = lat_write;
  assign dn_addr_o   = lat_addr;
  assign dn_wdata_o  = lat_wdata;
  assign dn_wstrb_o  = lat_wstrb;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= BUSY;
            grant_idx <= pick_idx;
            lat_write <= req_write_i[pick_idx];
            lat_addr  <= addr_arr[pick_idx];
            lat_wdata <= wdata_arr[pick_idx];
            lat_wstrb <= wstrb_arr[pick_idx];
          end
        end
        BUSY: begin
          if (done) begin
            state  <= IDLE;
            rr_ptr <= ptr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
